// File: rtl/fp_issue_ctrl_if.sv
// Bus bundle for the FP issue controller: decode request, FP unit
// start/done handshake and register-file writeback port.
interface fp_issue_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic             Req_Valid;
    logic             Req_Ready;
    logic             Req_Op;
    logic [WIDTH-1:0] Req_A;
    logic [WIDTH-1:0] Req_B;
    logic [AW-1:0]    Req_RA1;
    logic [AW-1:0]    Req_RA2;
    logic [AW-1:0]    Req_WA3;

    logic             FU_Start;
    logic [WIDTH-1:0] FU_Operand1;
    logic [WIDTH-1:0] FU_Operand2;
    logic [AW-1:0]    FU_WA3;
    logic             FU_Busy;
    logic             FU_Done;
    logic [WIDTH-1:0] FU_Result;
    logic [AW-1:0]    FU_RWA3;

    logic             WB_En;
    logic             WB_Ready;
    logic [AW-1:0]    WB_Addr;
    logic [WIDTH-1:0] WB_Data;

    modport master (
        input  Req_Valid, Req_Op, Req_A, Req_B,
        input  Req_RA1, Req_RA2, Req_WA3,
        output Req_Ready,
        output FU_Start, FU_Operand1, FU_Operand2, FU_WA3,
        input  FU_Busy, FU_Done, FU_Result, FU_RWA3,
        output WB_En, WB_Addr, WB_Data,
        input  WB_Ready
    );

    modport slave (
        output Req_Valid, Req_Op, Req_A, Req_B,
        output Req_RA1, Req_RA2, Req_WA3,
        input  Req_Ready,
        input  FU_Start, FU_Operand1, FU_Operand2, FU_WA3,
        output FU_Busy, FU_Done, FU_Result, FU_RWA3,
        input  WB_En, WB_Addr, WB_Data,
        output WB_Ready
    );
endinterface

// File: rtl/fp_issue_ctrl.sv
// FP issue controller: one op in flight, scoreboard of pending writebacks.
// Optional FP_ISSUE_STATS_EN adds Issue_Count / Timeout_Count outputs.
module fp_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int AW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              Reset,
    fp_issue_ctrl_if.master   bus,
    output logic [2**AW-1:0]  Pending,
    output logic              Err
`ifdef FP_ISSUE_STATS_EN
    ,
    output logic [15:0]       Issue_Count,
    output logic [7:0]        Timeout_Count
`endif
);
    localparam int NREG = 2**AW;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_COOL
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [AW-1:0]     tag_q, tag_d;
    logic [NREG-1:0]   pend_q, pend_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              start_q, start_d;
    logic              wb_en_q, wb_en_d;
    logic              err_q, err_d;

    logic hazard;
    logic ready;
    logic accept;
    logic unused_busy;

    assign unused_busy = bus.FU_Busy;

    assign hazard = pend_q[bus.Req_RA1]
                  | pend_q[bus.Req_RA2]
                  | pend_q[bus.Req_WA3];

    // Ready is forced low while Reset is held so the reset value is 0.
    assign ready  = (state_q == S_IDLE) & ~hazard & ~Reset;
    assign accept = bus.Req_Valid & ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        pend_d  = pend_q;
        timer_d = timer_q;
        data_d  = data_q;
        start_d = 1'b0;
        wb_en_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d = bus.Req_A;
                    b_d = {bus.Req_B[WIDTH-1] ^ bus.Req_Op,
                           bus.Req_B[WIDTH-2:0]};
                    tag_d = bus.Req_WA3;
                    pend_d[bus.Req_WA3] = 1'b1;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.FU_Done) begin
                    data_d  = bus.FU_Result;
                    err_d   = (bus.FU_RWA3 != tag_q);
                    wb_en_d = 1'b1;
                    state_d = S_WB;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_d == TMAX) begin
                        err_d = 1'b1;
                        pend_d[tag_q] = 1'b0;
                        state_d = S_COOL;
                    end
                end
            end
            S_WB: begin
                if (bus.WB_Ready) begin
                    pend_d[tag_q] = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    wb_en_d = 1'b1;
                end
            end
            S_COOL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            pend_q  <= '0;
            timer_q <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            wb_en_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            pend_q  <= pend_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            start_q <= start_d;
            wb_en_q <= wb_en_d;
            err_q   <= err_d;
        end
    end

    assign bus.Req_Ready   = ready;
    assign bus.FU_Start    = start_q;
    assign bus.FU_Operand1 = a_q;
    assign bus.FU_Operand2 = b_q;
    assign bus.FU_WA3      = tag_q;
    assign bus.WB_En       = wb_en_q;
    assign bus.WB_Addr     = tag_q;
    assign bus.WB_Data     = data_q;
    assign Pending         = pend_q;
    assign Err             = err_q;

`ifdef FP_ISSUE_STATS_EN
    logic [15:0] issue_cnt_q, issue_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q + {15'd0, start_q};
        tmo_cnt_d   = tmo_cnt_q;
        if ((state_q == S_WAIT) && (state_d == S_COOL)
            && (tmo_cnt_q != 8'hFF)) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            issue_cnt_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign Issue_Count   = issue_cnt_q;
    assign Timeout_Count = tmo_cnt_q;
`endif
endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Scoreboard bench for fp_issue_ctrl: FP unit model, random and
// directed requests, writeback monitor comparing against a queue.
module tb_fp_issue_ctrl;
    localparam int WIDTH   = 32;
    localparam int AW      = 4;
    localparam int TIMEOUT = 15;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [15:0] Pending;
    logic        Err;
`ifdef FP_ISSUE_STATS_EN
    logic [15:0] Issue_Count;
    logic [7:0]  Timeout_Count;
`endif

    fp_issue_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus();

    fp_issue_ctrl #(.WIDTH(WIDTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .bus           (bus.master),
        .Pending       (Pending),
        .Err           (Err)
`ifdef FP_ISSUE_STATS_EN
        ,
        .Issue_Count   (Issue_Count),
        .Timeout_Count (Timeout_Count)
`endif
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int n_issued = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wb_t;

    wb_t exp_q[$];

    // Stand-in FP adder: knows 1.0 + 2.0, otherwise a cheap mixing function.
    function automatic logic [31:0] fu_func(input logic [31:0] x,
                                            input logic [31:0] y);
        if (x == 32'h3F800000 && y == 32'h40000000)
            return 32'h40400000;
        return x ^ {y[15:0], y[31:16]};
    endfunction

    function automatic logic [31:0] ref_result(input logic op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] bb;
        bb = b;
        if (op) bb[31] = ~bb[31];
        return fu_func(a, bb);
    endfunction

    int          fu_delay  = 1;
    bit          fu_never  = 1'b0;
    bit          fu_badtag = 1'b0;
    bit          wb_rand   = 1'b0;

    // FP unit model
    initial begin : fu_model
        int          cd;
        bit          act;
        bit          bad;
        logic [31:0] o1, o2;
        logic [3:0]  tg;
        act = 0; bad = 0; cd = 0; o1 = 0; o2 = 0; tg = 0;
        bus.FU_Done   = 1'b0;
        bus.FU_Result = '0;
        bus.FU_RWA3   = '0;
        bus.FU_Busy   = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            bus.FU_Done = 1'b0;
            if (Reset) begin
                act = 0;
            end else begin
                if (act) begin
                    cd--;
                    if (cd <= 0) begin
                        bus.FU_Done   = 1'b1;
                        bus.FU_Result = fu_func(o1, o2);
                        bus.FU_RWA3   = bad ? (tg ^ 4'h1) : tg;
                        act = 0;
                    end
                end
                if (bus.FU_Start) begin
                    o1  = bus.FU_Operand1;
                    o2  = bus.FU_Operand2;
                    tg  = bus.FU_WA3;
                    bad = fu_badtag;
                    cd  = (fu_delay == 0) ? $urandom_range(1, 4) : fu_delay;
                    act = !fu_never;
                end
            end
            bus.FU_Busy = act;
        end
    end

    initial begin : wb_driver
        forever begin
            @(posedge CLK);
            #1;
            if (wb_rand) bus.WB_Ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Writeback monitor
    initial begin : monitor
        wb_t e;
        forever begin
            @(negedge CLK);
            if (!Reset && bus.WB_En && bus.WB_Ready) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_addr", bus.WB_Addr, e.addr);
                    chk("wb_data", bus.WB_Data, e.data);
                    chk("wb_pending", Pending[e.addr], 1);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] ra1,
                         input logic [3:0] ra2, input logic [3:0] wa3,
                         input bit push);
        bit ok;
        ok = 0;
        bus.Req_Op    = op;
        bus.Req_A     = a;
        bus.Req_B     = b;
        bus.Req_RA1   = ra1;
        bus.Req_RA2   = ra2;
        bus.Req_WA3   = wa3;
        bus.Req_Valid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge CLK);
            if (bus.Req_Ready) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            if (push) exp_q.push_back('{addr: wa3, data: ref_result(op, a, b)});
            n_issued++;
        end else begin
            chk("req_accept_timeout", 64'd0, 64'd1);
        end
        cyc();
        bus.Req_Valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && bus.Req_Ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 64'd0, 64'd1);
        cyc();
    endtask

    task automatic wait_wb_en();
        bit ok;
        ok = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK);
            if (bus.WB_En) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("wb_en_timeout", 64'd0, 64'd1);
    endtask

    initial begin : main
        logic [3:0]  sv_addr;
        logic [31:0] sv_data;
        Reset         = 1'b1;
        bus.Req_Valid = 1'b0;
        bus.Req_Op    = 1'b0;
        bus.Req_A     = '0;
        bus.Req_B     = '0;
        bus.Req_RA1   = '0;
        bus.Req_RA2   = '0;
        bus.Req_WA3   = '0;
        bus.WB_Ready  = 1'b0;
        cyc();
        cyc();
        @(negedge CLK);
        chk("rst_req_ready", bus.Req_Ready, 0);
        chk("rst_fu_start", bus.FU_Start, 0);
        chk("rst_wb_en", bus.WB_En, 0);
        chk("rst_err", Err, 0);
        chk("rst_pending", Pending, 0);
        chk("rst_wb_data", bus.WB_Data, 0);
        chk("rst_wb_addr", bus.WB_Addr, 0);
        chk("rst_fu_op1", bus.FU_Operand1, 0);
        cyc();
        Reset = 1'b0;
        bus.WB_Ready = 1'b1;
        cyc();

        // ADD 1.0 + 2.0 with cycle-exact timing and hazard on reg 5
        bus.Req_Op = 1'b0;
        bus.Req_A = 32'h3F800000;
        bus.Req_B = 32'h40000000;
        bus.Req_RA1 = 4'd0;
        bus.Req_RA2 = 4'd1;
        bus.Req_WA3 = 4'd5;
        bus.Req_Valid = 1'b1;
        @(negedge CLK);
        chk("add_ready_t", bus.Req_Ready, 1);
        chk("add_start_t", bus.FU_Start, 0);
        exp_q.push_back('{addr: 4'd5, data: 32'h40400000});
        n_issued++;
        cyc();
        bus.Req_Valid = 1'b0;
        bus.Req_RA1 = 4'd5;
        @(negedge CLK);
        chk("add_start_t1", bus.FU_Start, 1);
        chk("add_op1_t1", bus.FU_Operand1, 32'h3F800000);
        chk("add_op2_t1", bus.FU_Operand2, 32'h40000000);
        chk("add_tag_t1", bus.FU_WA3, 5);
        chk("add_pend_t1", Pending, 16'h0020);
        chk("hazard_ready_t1", bus.Req_Ready, 0);
        cyc();
        @(negedge CLK);
        chk("add_start_t2", bus.FU_Start, 0);
        chk("add_wb_en_t2", bus.WB_En, 0);
        chk("add_pend_t2", Pending[5], 1);
        chk("hazard_ready_t2", bus.Req_Ready, 0);
        cyc();
        @(negedge CLK);
        chk("add_wb_en_t3", bus.WB_En, 1);
        chk("add_wb_addr_t3", bus.WB_Addr, 5);
        chk("add_wb_data_t3", bus.WB_Data, 32'h40400000);
        chk("add_pend_t3", Pending[5], 1);
        chk("hazard_ready_t3", bus.Req_Ready, 0);
        cyc();
        @(negedge CLK);
        chk("add_wb_en_t4", bus.WB_En, 0);
        chk("add_pend_t4", Pending, 0);
        chk("hazard_ready_t4", bus.Req_Ready, 1);
        cyc();

        // SUB flips B sign, A untouched
        bus.Req_Op = 1'b1;
        bus.Req_A = 32'h12345678;
        bus.Req_B = 32'h40000000;
        bus.Req_RA1 = 4'd2;
        bus.Req_RA2 = 4'd3;
        bus.Req_WA3 = 4'd6;
        bus.Req_Valid = 1'b1;
        @(negedge CLK);
        chk("sub_ready", bus.Req_Ready, 1);
        exp_q.push_back('{addr: 4'd6,
                          data: ref_result(1'b1, 32'h12345678, 32'h40000000)});
        n_issued++;
        cyc();
        bus.Req_Valid = 1'b0;
        @(negedge CLK);
        chk("sub_op2", bus.FU_Operand2, 32'hC0000000);
        chk("sub_op1", bus.FU_Operand1, 32'h12345678);
        drain();

        // Writeback stalled by WB_Ready low for three cycles
        bus.WB_Ready = 1'b0;
        issue(1'b0, 32'hA5A5F00F, 32'h0F0F1234, 4'd1, 4'd2, 4'd12, 1'b1);
        wait_wb_en();
        sv_addr = bus.WB_Addr;
        sv_data = bus.WB_Data;
        chk("stall_addr", sv_addr, 12);
        chk("stall_data", sv_data,
            ref_result(1'b0, 32'hA5A5F00F, 32'h0F0F1234));
        for (int k = 0; k < 3; k++) begin
            chk("stall_wb_en", bus.WB_En, 1);
            chk("stall_addr_hold", bus.WB_Addr, sv_addr);
            chk("stall_data_hold", bus.WB_Data, sv_data);
            chk("stall_no_accept", bus.Req_Ready, 0);
            cyc();
            @(negedge CLK);
        end
        chk("stall_wb_en_4th", bus.WB_En, 1);
        cyc();
        bus.WB_Ready = 1'b1;
        @(negedge CLK);
        chk("stall_wb_en_last", bus.WB_En, 1);
        cyc();
        @(negedge CLK);
        chk("stall_wb_en_done", bus.WB_En, 0);
        chk("stall_pend_done", Pending, 0);
        cyc();

        // FP unit never answers: timeout abort
        fu_never = 1'b1;
        issue(1'b0, 32'h11112222, 32'h33334444, 4'd1, 4'd2, 4'd9, 1'b0);
        for (int k = 0; k < 15; k++) cyc();
        @(negedge CLK);
        chk("tmo_err_before", Err, 0);
        chk("tmo_pend_before", Pending[9], 1);
        cyc();
        @(negedge CLK);
        chk("tmo_err", Err, 1);
        chk("tmo_pend_clr", Pending, 0);
        chk("tmo_cool_ready", bus.Req_Ready, 0);
`ifdef FP_ISSUE_STATS_EN
        chk("tmo_count", Timeout_Count, 1);
`endif
        cyc();
        @(negedge CLK);
        chk("tmo_err_pulse", Err, 0);
        chk("tmo_idle_ready", bus.Req_Ready, 1);
        cyc();
        fu_never = 1'b0;

        // Returned tag mismatch: Err pulse, writeback to latched tag
        fu_badtag = 1'b1;
        issue(1'b1, 32'hDEADBEEF, 32'hBF800000, 4'd0, 4'd0, 4'd3, 1'b1);
        wait_wb_en();
        chk("tag_err", Err, 1);
        chk("tag_wb_addr", bus.WB_Addr, 3);
        cyc();
        @(negedge CLK);
        chk("tag_err_pulse", Err, 0);
        fu_badtag = 1'b0;
        drain();

        // Reset while waiting on the FP unit
        fu_delay = 10;
        issue(1'b0, 32'h11111111, 32'h22222222, 4'd0, 4'd0, 4'd7, 1'b0);
        cyc();
        chk("mid_pend_pre", Pending[7], 1);
        Reset = 1'b1;
        n_issued = 0;
        #1;
        chk("mid_req_ready", bus.Req_Ready, 0);
        chk("mid_fu_start", bus.FU_Start, 0);
        chk("mid_wb_en", bus.WB_En, 0);
        chk("mid_err", Err, 0);
        chk("mid_pending", Pending, 0);
        chk("mid_wb_data", bus.WB_Data, 0);
        chk("mid_wb_addr", bus.WB_Addr, 0);
        chk("mid_fu_ops", {bus.FU_Operand1, bus.FU_Operand2}, 0);
        chk("mid_fu_tag", bus.FU_WA3, 0);
        cyc();
        cyc();
        Reset = 1'b0;
        fu_delay = 1;
        cyc();
        issue(1'b0, 32'h01020304, 32'h0A0B0C0D, 4'd4, 4'd5, 4'd7, 1'b1);
        drain();

        // Randomised traffic with random FP latency and writeback stalls
        wb_rand = 1'b1;
        fu_delay = 0;
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)), $urandom, $urandom,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'b1);
        end
        drain();
        wb_rand = 1'b0;
        bus.WB_Ready = 1'b1;
        fu_delay = 1;

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("final_pending", Pending, 0);
`ifdef FP_ISSUE_STATS_EN
        chk("issue_count", Issue_Count, 16'(n_issued));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
